// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame states,
// scancode prefixes and the keyboard_data field layout.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_REL_PREFIX = 8'hF0;

  localparam int KD_VALID_BIT = 15;
  localparam int KD_OVF_BIT   = 14;
  localparam int KD_EXT_BIT   = 13;
  localparam int KD_REL_BIT   = 12;
  localparam int KD_CODE_MSB  = 7;
  localparam int KD_CODE_LSB  = 0;

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronizes the raw PS/2 clock, rejects glitches shorter than FILTER_LEN
// samples and emits a one-cycle strobe on each filtered falling edge.
module ps2_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic fall_strobe
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] run_cnt;

  // The level only flips once the new value has been seen FILTER_LEN times in a row
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      run_cnt <= '0;
    end else begin
      sync1   <= pin;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_LAST) begin
        level   <= sync2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
    end
  end

  assign fall_strobe = level_d & ~level;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames bytes off the filtered device clock, folds
// E0/F0 prefixes into flags and publishes a 16-bit status word for the CPU.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FILTER_LEN     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        clear,
  output logic [15:0] keyboard_data
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state;
  logic          data_s1;
  logic          data_s2;
  logic          strobe;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [TW-1:0] to_cnt;
  logic          ext_pending;
  logic          rel_pending;
  logic          frame_good;
  logic          is_prefix;
  logic [15:0]   publish_word;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk         (clk),
    .reset       (reset),
    .pin         (ps2_clk),
    .fall_strobe (strobe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  assign is_prefix = (shift_reg == PS2_EXT_PREFIX) || (shift_reg == PS2_REL_PREFIX);

  // Overflow is flagged only when an unread code is overwritten and the CPU is not reading it now
  always_comb begin
    publish_word                          = '0;
    publish_word[KD_VALID_BIT]            = 1'b1;
    publish_word[KD_OVF_BIT]              = keyboard_data[KD_VALID_BIT] & ~clear;
    publish_word[KD_EXT_BIT]              = ext_pending;
    publish_word[KD_REL_BIT]              = rel_pending;
    publish_word[KD_CODE_MSB:KD_CODE_LSB] = shift_reg;
  end

  // frame_good marks the cycle after an accepted stop bit; shift_reg still holds that byte
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      parity_bit    <= 1'b0;
      to_cnt        <= '0;
      ext_pending   <= 1'b0;
      rel_pending   <= 1'b0;
      frame_good    <= 1'b0;
      keyboard_data <= '0;
    end else begin
      frame_good <= 1'b0;

      if (frame_good && !is_prefix) begin
        keyboard_data <= publish_word;
        ext_pending   <= 1'b0;
        rel_pending   <= 1'b0;
      end else begin
        if (frame_good && shift_reg == PS2_EXT_PREFIX) ext_pending <= 1'b1;
        if (frame_good && shift_reg == PS2_REL_PREFIX) rel_pending <= 1'b1;
        if (clear) keyboard_data <= '0;
      end

      if (state == ST_IDLE) begin
        to_cnt <= '0;
        if (strobe && !data_s2) begin
          state   <= ST_DATA;
          bit_cnt <= '0;
        end
      end else if (strobe) begin
        to_cnt <= '0;
        case (state)
          ST_DATA: begin
            shift_reg <= {data_s2, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_bit <= data_s2;
            state      <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (data_s2 && (^{shift_reg, parity_bit})) begin
              frame_good <= 1'b1;
            end else begin
              ext_pending <= 1'b0;
              rel_pending <= 1'b0;
            end
          end
        endcase
      end else if (to_cnt == TO_LAST) begin
        // A stalled device must not leave a half frame waiting forever
        state       <= ST_IDLE;
        to_cnt      <= '0;
        ext_pending <= 1'b0;
        rel_pending <= 1'b0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: bit-bangs PS/2 frames and scores
// every keyboard_data change against a queue of expected words.
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int HALF_BIT       = 20;
  localparam int LAT            = 2 + FILTER_LEN + 2;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic        clear    = 1'b0;
  logic [15:0] keyboard_data;

  int          checks   = 0;
  int          errors   = 0;
  int          cyc      = 0;
  int          stop_cyc = 0;
  int          upd_cyc  = -1000;
  logic [15:0] exp_q[$];
  logic [15:0] prev_kd  = 16'h0000;
  logic [15:0] sb_exp;

  ps2_keyboard_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FILTER_LEN     (FILTER_LEN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .clear         (clear),
    .keyboard_data (keyboard_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard: every change of keyboard_data outside reset must match the next queued word
  always @(negedge clk) begin
    if (reset) begin
      prev_kd = keyboard_data;
    end else if (keyboard_data !== prev_kd) begin
      upd_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_update got %h expected no update", keyboard_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (keyboard_data !== sb_exp) begin
          errors++;
          $display("[TB] FAIL scoreboard got %h expected %h", keyboard_data, sb_exp);
        end
      end
      prev_kd = keyboard_data;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic clr_pub);
    ps2_data = b;
    wait_cycles(HALF_BIT);
    ps2_clk  = 1'b0;
    stop_cyc = cyc;
    for (int i = 1; i <= HALF_BIT; i++) begin
      @(posedge clk);
      #1;
      if (clr_pub && i == LAT - 1) clear = 1'b1;
      if (clr_pub && i == LAT) clear = 1'b0;
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par,
                            input logic bad_stop, input logic clr_pub);
    logic par;
    par = (~^code) ^ bad_par;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i], 1'b0);
    send_bit(par, 1'b0);
    send_bit(~bad_stop, clr_pub);
    ps2_data = 1'b1;
    wait_cycles(HALF_BIT);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    wait_cycles(1);
    clear = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(5);
    checks++;
    if (keyboard_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_value got %h expected 0000", keyboard_data);
    end
    reset = 1'b0;
    wait_cycles(5);
    checks++;
    if (keyboard_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got %h expected 0000", keyboard_data);
    end
  endtask

  task automatic test_single_frame();
    exp_q.push_back(16'h801C);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    checks++;
    if (upd_cyc - stop_cyc !== LAT) begin
      errors++;
      $display("[TB] FAIL latency got %0d expected %0d", upd_cyc - stop_cyc, LAT);
    end
    checks++;
    if (keyboard_data !== 16'h801C) begin
      errors++;
      $display("[TB] FAIL single_frame got %h expected 801c", keyboard_data);
    end
    exp_q.push_back(16'h0000);
    pulse_clear();
  endtask

  task automatic test_prefixes();
    exp_q.push_back(16'hB074);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0, 1'b0);
    checks++;
    if (keyboard_data !== 16'hB074) begin
      errors++;
      $display("[TB] FAIL prefixes got %h expected b074", keyboard_data);
    end
    exp_q.push_back(16'h0000);
    pulse_clear();
  endtask

  task automatic test_bad_frames();
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    checks++;
    if (keyboard_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL bad_parity_kept got %h expected 0000", keyboard_data);
    end
    exp_q.push_back(16'h8032);
    send_frame(8'h32, 1'b0, 1'b0, 1'b0);
    checks++;
    if (keyboard_data !== 16'h8032) begin
      errors++;
      $display("[TB] FAIL after_bad_parity got %h expected 8032", keyboard_data);
    end
    exp_q.push_back(16'h0000);
    pulse_clear();
    // A bad frame between a prefix and its code must drop the prefix
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(16'h8074);
    send_frame(8'h74, 1'b0, 1'b0, 1'b0);
    checks++;
    if (keyboard_data !== 16'h8074) begin
      errors++;
      $display("[TB] FAIL parity_drops_ext got %h expected 8074", keyboard_data);
    end
    exp_q.push_back(16'h0000);
    pulse_clear();
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(16'h8074);
    send_frame(8'h74, 1'b0, 1'b0, 1'b0);
    checks++;
    if (keyboard_data !== 16'h8074) begin
      errors++;
      $display("[TB] FAIL stop_drops_rel got %h expected 8074", keyboard_data);
    end
    exp_q.push_back(16'h0000);
    pulse_clear();
  endtask

  task automatic test_overflow();
    exp_q.push_back(16'h801C);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(16'hC032);
    send_frame(8'h32, 1'b0, 1'b0, 1'b0);
    checks++;
    if (keyboard_data !== 16'hC032) begin
      errors++;
      $display("[TB] FAIL overflow got %h expected c032", keyboard_data);
    end
    exp_q.push_back(16'h0000);
    pulse_clear();
    checks++;
    if (keyboard_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL clear_after_ovf got %h expected 0000", keyboard_data);
    end
  endtask

  task automatic test_clear_on_publish();
    exp_q.push_back(16'h801C);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(16'h8032);
    send_frame(8'h32, 1'b0, 1'b0, 1'b1);
    checks++;
    if (keyboard_data !== 16'h8032) begin
      errors++;
      $display("[TB] FAIL clear_on_publish got %h expected 8032", keyboard_data);
    end
    exp_q.push_back(16'h0000);
    pulse_clear();
  endtask

  task automatic test_clear_idle();
    pulse_clear();
    checks++;
    if (keyboard_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL clear_idle got %h expected 0000", keyboard_data);
    end
  endtask

  task automatic test_timeout();
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    ps2_data = 1'b1;
    wait_cycles(TIMEOUT_CYCLES + 50);
    exp_q.push_back(16'h801C);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    checks++;
    if (keyboard_data !== 16'h801C) begin
      errors++;
      $display("[TB] FAIL timeout_recover got %h expected 801c", keyboard_data);
    end
    exp_q.push_back(16'h0000);
    pulse_clear();
  endtask

  task automatic test_glitch();
    ps2_data = 1'b0;
    wait_cycles(5);
    ps2_clk = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b1;
    wait_cycles(10);
    ps2_data = 1'b1;
    wait_cycles(30);
    exp_q.push_back(16'h8074);
    send_frame(8'h74, 1'b0, 1'b0, 1'b0);
    checks++;
    if (keyboard_data !== 16'h8074) begin
      errors++;
      $display("[TB] FAIL glitch_ignored got %h expected 8074", keyboard_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    reset = 1'b1;
    wait_cycles(3);
    checks++;
    if (keyboard_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_frame got %h expected 0000", keyboard_data);
    end
    reset    = 1'b0;
    ps2_data = 1'b1;
    wait_cycles(5);
    exp_q.push_back(16'h801C);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    checks++;
    if (keyboard_data !== 16'h801C) begin
      errors++;
      $display("[TB] FAIL frame_after_reset got %h expected 801c", keyboard_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_prefixes();
    test_bad_frames();
    test_overflow();
    test_clear_on_publish();
    test_clear_idle();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    wait_cycles(5);
    while (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_update got none expected %h", sb_exp);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 200000, frame-abort timeout in clk cycles (2 ms at 100 MHz).
REQ-002 SHALL have parameter FILTER_LEN, default 8, consecutive equal samples needed to accept a ps2_clk level change.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ps2_clk  input  1  asynchronous PS/2 device clock.
REQ-006 SHALL have port ps2_data  input  1  asynchronous PS/2 device data.
REQ-007 SHALL have port clear  input  1  one-cycle pulse from CPU I/O store; consumes current code.
REQ-008 SHALL have port keyboard_data  output  16  {valid[15], overflow[14], extended[13], release[12], 4'b0, scancode[7:0]}, registered.

Function
REQ-009 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-010 SHALL change filtered ps2_clk level only after FILTER_LEN consecutive identical synchronized samples; shorter glitches ignored.
REQ-011 SHALL detect a falling edge of filtered ps2_clk as a one-cycle strobe; each strobe samples synchronized ps2_data once.
REQ-012 SHALL run frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on strobes.
REQ-013 IDLE: sampled 0 (start) -> DATA with bit count 0; sampled 1 -> stay IDLE.
REQ-014 DATA: shift 8 bits LSB first; after 8th bit -> PARITY.
REQ-015 PARITY: store bit; -> STOP.
REQ-016 STOP: frame good iff stop bit = 1 and XOR of 8 data bits and parity bit = 1 (odd parity); -> IDLE always.
REQ-017 Bad frame (parity or stop error) SHALL be discarded and clear extended/release pending flags; keyboard_data unchanged.
REQ-018 In any non-IDLE state, TIMEOUT_CYCLES clk cycles without a strobe SHALL force IDLE, discard partial frame, clear pending flags.
REQ-019 Good byte 8'hE0 SHALL set ext_pending; 8'hF0 SHALL set rel_pending; neither publishes.
REQ-020 Any other good byte SHALL publish {1, ovf, ext_pending, rel_pending, 4'b0, byte} on the clk edge after the stop-bit strobe, then clear both pending flags.
REQ-021 ovf on publish SHALL be 1 if valid was 1 and clear not asserted that cycle, else 0; older code overwritten.
REQ-022 clear without publish SHALL set keyboard_data to 16'h0000 next edge; clear while valid=0 harmless.
REQ-023 Simultaneous clear and publish: publish wins with overflow = 0.
REQ-024 Latency ps2_clk stop-bit falling edge (pin) to keyboard_data update SHALL be exactly 2 + FILTER_LEN + 2 clk cycles.

Reset
REQ-025 On reset: keyboard_data = 16'h0000, FSM = IDLE, bit count, shift register, pending flags, timeout counter = 0, synchronizers and filtered clock = 1 (bus idle).
REQ-026 Reset mid-frame SHALL abandon frame; first frame after reset decoded normally.

Structure
REQ-027 Package ps2_pkg SHALL hold FSM state enum, constants PS2_EXT_PREFIX = 8'hE0, PS2_REL_PREFIX = 8'hF0, keyboard_data field bit positions.
REQ-028 Synchronizer + glitch filter + falling-edge strobe SHALL be sub-module ps2_input_filter (one instance for ps2_clk; ps2_data uses synchronizer only).

Verification
REQ-029 Frame 0x1C (parity 0, stop 1) from reset -> keyboard_data = 16'h801C at REQ-024 latency.
REQ-030 Frames E0, F0, 74 -> single update 16'hB074; no update after E0 or F0.
REQ-031 Frame 0x1C with parity 1 -> keyboard_data stays 16'h0000; following good 0x32 -> 16'h8032.
REQ-032 0x1C then 0x32, no clear -> 16'hC032; clear pulse -> 16'h0000.
REQ-033 0x1C, then clear asserted on 0x32 publish edge -> 16'h8032 (overflow 0).
REQ-034 Start + 4 data bits, ps2_clk idle TIMEOUT_CYCLES+1 -> FSM IDLE; next frame 0x1C -> 16'h801C; 3-cycle ps2_clk glitch -> no strobe.
